kim1_display_keypad: RTL and testbench

Board-side model of the KIM-1 six-digit LED display and 3x7 keypad matrix.
- Sits directly downstream of the 6530 port A/B outputs (PAO/DDRA/PBO/DDRB) and feeds the port A input (PAI) back to it.
- Decodes the 74145 select code on PB4..PB1, captures the segment pattern for each digit, and scans debounced keys onto PA6..PA0.
- Presents the latched display and the current key to host/test logic.

---
 rtl/kim1_pkg.sv | 11 +
 rtl/kim1_key_debounce.sv | 43 ++++
 rtl/kim1_display_keypad.sv | 145 ++++++++++++++
 tb/tb_kim1_display_keypad.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/kim1_pkg.sv
// Shared sizes and types for the KIM-1 display/keypad board model.
package kim1_pkg;
    localparam int NUM_DIGITS     = 6;
    localparam int NUM_ROWS       = 3;
    localparam int NUM_COLS       = 7;
    localparam int NUM_KEYS       = 21;
    localparam int SEL_DIGIT_BASE = 4;

    typedef logic [3:0] sel_t;
    typedef logic [6:0] seg_t;
endpackage

// File: rtl/kim1_key_debounce.sv
// Keypad conditioning: 2-flop synchronizer, tick prescaler, and a two-sample
// agreement filter so a key only changes state when two consecutive ticks agree.
module kim1_key_debounce
    import kim1_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_KEYS-1:0] keys_i,
    output logic [NUM_KEYS-1:0] key_db_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0]       pre_q, pre_d;
    logic                tick;
    logic [NUM_KEYS-1:0] sync1_q, sync2_q, samp_q, db_q, db_d, agree;

    assign tick  = (pre_q == CW'(DEBOUNCE_CYCLES - 1));
    assign pre_d = tick ? '0 : pre_q + 1'b1;
    assign agree = ~(sync2_q ^ samp_q);
    assign db_d  = (agree & sync2_q) | (~agree & db_q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
            db_q    <= '0;
            pre_q   <= '0;
        end else begin
            sync1_q <= keys_i;
            sync2_q <= sync1_q;
            pre_q   <= pre_d;
            if (tick) begin
                samp_q <= sync2_q;
                db_q   <= db_d;
            end
        end
    end

    assign key_db_o = db_q;
endmodule

// File: rtl/kim1_display_keypad.sv
// KIM-1 six-digit LED display and 3x7 keypad matrix driven from the 6530 ports.
// Optional KIM1_TTY_LOOP_EN routes tty_rx onto PA7 and PB0 onto tty_tx.
module kim1_display_keypad
    import kim1_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int SETTLE_CYCLES   = 16,
    parameter int PERSIST_CYCLES  = 100000
) (
    input  logic                phi2,
    input  logic                rst,
    input  logic [7:0]          PAO,
    input  logic [7:0]          DDRA,
    input  logic [7:0]          PBO,
    input  logic [7:0]          DDRB,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                tty_rx,
    output logic [7:0]          PAI,
    output logic                tty_tx,
    output logic [41:0]         digit_seg,
    output logic [5:0]          digit_valid,
    output logic [4:0]          key_code,
    output logic                key_valid
);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW = $clog2(PERSIST_CYCLES + 1);

    logic [7:0]                         pb_pin, pin, pai_q, pai_d;
    sel_t                               sel, selp_q;
    seg_t                               seg, cand_q;
    logic [NUM_KEYS-1:0]                key_db;
    logic [NUM_DIGITS-1:0]              dig_sel, dval_q, dval_d;
    logic [NUM_DIGITS-1:0][6:0]         dseg_q, dseg_d;
    logic [NUM_DIGITS-1:0][PW-1:0]      pers_q, pers_d;
    logic [SW-1:0]                      stab_q, stab_d;
    logic                               latch, pin7, kv_q;
    logic [6:0]                         row_pin;
    logic [4:0]                         kc_q, kc_d;
    logic                               unused_ok;

    assign pb_pin = PBO | ~DDRB;
    assign sel    = pb_pin[4:1];
    assign seg    = PAO[6:0] & DDRA[6:0];

    kim1_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk_i    (phi2),
        .rst_i    (rst),
        .keys_i   (keys),
        .key_db_o (key_db)
    );

    // A select change counts as instability, so it wins over the settle compare.
    always_comb begin
        stab_d = stab_q;
        if (seg != cand_q || sel != selp_q)
            stab_d = '0;
        else if (stab_q != SW'(SETTLE_CYCLES))
            stab_d = stab_q + 1'b1;
    end
    assign latch = (stab_d == SW'(SETTLE_CYCLES)) && (seg != '0);

    always_comb begin
        dseg_d = dseg_q;
        dval_d = dval_q;
        pers_d = pers_q;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            dig_sel[d] = (sel == sel_t'(SEL_DIGIT_BASE + d));
            if (dig_sel[d]) begin
                pers_d[d] = '0;
                if (latch) begin
                    dseg_d[d] = seg;
                    dval_d[d] = 1'b1;
                end
            end else if (pers_q[d] == PW'(PERSIST_CYCLES)) begin
                dseg_d[d] = '0;
                dval_d[d] = 1'b0;
            end else begin
                pers_d[d] = pers_q[d] + 1'b1;
            end
        end
    end

    always_comb begin
        row_pin = '1;
        for (int r = 0; r < NUM_ROWS; r++)
            if (sel == sel_t'(r)) row_pin = ~key_db[r*NUM_COLS +: NUM_COLS];
        pin   = {pin7, row_pin};
        pai_d = (DDRA & PAO) | (~DDRA & pin);
        kc_d  = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--)
            if (key_db[k]) kc_d = 5'(k);
    end

`ifdef KIM1_TTY_LOOP_EN
    logic rx1_q, rx2_q, tx_q;
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            rx1_q <= 1'b0;
            rx2_q <= 1'b0;
            tx_q  <= 1'b1;
        end else begin
            rx1_q <= tty_rx;
            rx2_q <= rx1_q;
            tx_q  <= pb_pin[0];
        end
    end
    assign pin7      = rx2_q;
    assign tty_tx    = tx_q;
    assign unused_ok = ^pb_pin[7:5];
`else
    assign pin7      = 1'b1;
    assign tty_tx    = 1'b1;
    assign unused_ok = ^{tty_rx, pb_pin[7:5], pb_pin[0]};
`endif

    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            pai_q  <= 8'hFF;
            kc_q   <= '0;
            kv_q   <= 1'b0;
            stab_q <= '0;
            cand_q <= '0;
            selp_q <= '0;
            dseg_q <= '0;
            dval_q <= '0;
            pers_q <= '0;
        end else begin
            pai_q  <= pai_d;
            kc_q   <= kc_d;
            kv_q   <= |key_db;
            stab_q <= stab_d;
            cand_q <= seg;
            selp_q <= sel;
            dseg_q <= dseg_d;
            dval_q <= dval_d;
            pers_q <= pers_d;
        end
    end

    assign PAI         = pai_q;
    assign digit_seg   = dseg_q;
    assign digit_valid = dval_q;
    assign key_code    = kc_q;
    assign key_valid   = kv_q;
endmodule

// File: tb/tb_kim1_display_keypad.sv
// Directed bench for kim1_display_keypad: reset, digit capture/persistence,
// keypad debounce and PA readback, table-driven select/readback vectors.
module tb_kim1_display_keypad;
    localparam int DEB  = 1000;
    localparam int PERS = 500;

    logic        phi2 = 1'b0;
    logic        rst;
    logic [7:0]  PAO, DDRA, PBO, DDRB, PAI;
    logic [20:0] keys;
    logic        tty_rx, tty_tx, key_valid;
    logic [41:0] digit_seg;
    logic [5:0]  digit_valid;
    logic [4:0]  key_code;

    int n_cmp = 0;
    int n_err = 0;

    kim1_display_keypad #(
        .DEBOUNCE_CYCLES (DEB),
        .SETTLE_CYCLES   (16),
        .PERSIST_CYCLES  (PERS)
    ) dut (
        .phi2        (phi2),
        .rst         (rst),
        .PAO         (PAO),
        .DDRA        (DDRA),
        .PBO         (PBO),
        .DDRB        (DDRB),
        .keys        (keys),
        .tty_rx      (tty_rx),
        .PAI         (PAI),
        .tty_tx      (tty_tx),
        .digit_seg   (digit_seg),
        .digit_valid (digit_valid),
        .key_code    (key_code),
        .key_valid   (key_valid)
    );

    always #5 phi2 = ~phi2;

    typedef struct {
        logic [7:0] ddra, pao, ddrb, pbo;
        logic [7:0] exp_pai;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge phi2);
    endtask

    logic seen_kv, seen_pai;

    initial begin
        // key 9 (row 1, col 2) is held while these run
        vt[0] = '{8'h00, 8'h00, 8'h1E, 8'h02, 8'hFB};
        vt[1] = '{8'h00, 8'h00, 8'h1E, 8'h00, 8'hFF};
        vt[2] = '{8'h00, 8'h00, 8'h1E, 8'h04, 8'hFF};
        vt[3] = '{8'h00, 8'h00, 8'h1E, 8'h06, 8'hFF};
        vt[4] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        vt[5] = '{8'h00, 8'h00, 8'h1C, 8'h00, 8'hFB};
        vt[6] = '{8'hFF, 8'h3C, 8'h1E, 8'h02, 8'h3C};
        vt[7] = '{8'hF0, 8'hA0, 8'h1E, 8'h02, 8'hAB};
        vt[8] = '{8'h04, 8'h04, 8'h1E, 8'h02, 8'hFF};

        rst = 1'b1; PAO = 0; DDRA = 0; PBO = 0; DDRB = 0; keys = 0; tty_rx = 1'b1;
        #22 rst = 1'b0;
        cyc(1);
        chk("rst_pai", PAI, 8'hFF);
        chk("rst_seg", digit_seg, 42'h0);
        chk("rst_dvalid", digit_valid, 6'h0);
        chk("rst_kcode", key_code, 5'h0);
        chk("rst_kvalid", key_valid, 1'b0);
        chk("rst_tty_tx", tty_tx, 1'b1);

        // digit 0 capture
        DDRB = 8'h1E; PBO = 8'h08; DDRA = 8'h7F; PAO = 8'h06;
        cyc(10);
        chk("settle_early", digit_valid, 6'h00);
        cyc(10);
        chk("cap_seg0", digit_seg[6:0], 7'h06);
        chk("cap_valid", digit_valid, 6'b000001);
        chk("cap_pai", PAI, 8'h86);
        PAO = 8'h00;
        cyc(20);
        chk("blank_ignored", digit_seg[6:0], 7'h06);

        // persistence: move to digit 1
        PBO = 8'h0A; PAO = 8'h5B;
        cyc(PERS - 10);
        chk("pers_before", digit_valid, 6'b000011);
        chk("dig1_seg", digit_seg[13:7], 7'h5B);
        cyc(20);
        chk("pers_expired", digit_valid, 6'b000010);
        chk("pers_seg0", digit_seg[6:0], 7'h00);
        chk("pers_seg1", digit_seg[13:7], 7'h5B);

        // key 9 on row 1
        PAO = 0; DDRA = 0; PBO = 8'h02; keys[9] = 1'b1;
        cyc(3 * DEB + 10);
        chk("key_pai", PAI, 8'hFB);
        chk("key_code9", key_code, 5'd9);
        chk("key_valid9", key_valid, 1'b1);

        for (int i = 0; i < 9; i++) begin
            DDRA = vt[i].ddra; PAO = vt[i].pao; DDRB = vt[i].ddrb; PBO = vt[i].pbo;
            cyc(2);
            chk($sformatf("vec%0d_pai", i), PAI, vt[i].exp_pai);
        end
        chk("vec_kcode", key_code, 5'd9);

        // asynchronous reset between edges
        @(posedge phi2); #2 rst = 1'b1; #1;
        chk("arst_pai", PAI, 8'hFF);
        chk("arst_dvalid", digit_valid, 6'h0);
        chk("arst_kvalid", key_valid, 1'b0);
        chk("arst_seg", digit_seg, 42'h0);
        keys = 0; DDRA = 0; PAO = 0; DDRB = 8'h1E; PBO = 8'h00;
        @(negedge phi2); rst = 1'b0;
        cyc(5);
        chk("arst_hold_pai", PAI, 8'hFF);
        chk("arst_hold_kv", key_valid, 1'b0);

        // half period 8 divides into an odd number of toggles per tick period,
        // so consecutive debounce samples always disagree
        seen_kv = 1'b0; seen_pai = 1'b0;
        for (int i = 0; i < 375; i++) begin
            repeat (8) begin
                @(negedge phi2);
                if (key_valid !== 1'b0) seen_kv = 1'b1;
                if (PAI !== 8'hFF) seen_pai = 1'b1;
            end
            keys[0] = ~keys[0];
        end
        keys[0] = 1'b0;
        chk("bounce_kvalid", seen_kv, 1'b0);
        chk("bounce_pai", seen_pai, 1'b0);

        // readback mixed with row 0 keys 1 and 5
        keys[1] = 1'b1; keys[5] = 1'b1; DDRA = 8'h0F; PAO = 8'h05;
        cyc(2 * DEB + 100);
        chk("mix_pai", PAI, 8'hD5);
        chk("mix_kcode", key_code, 5'd1);
        chk("mix_kvalid", key_valid, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
